sram1rw_ctrl: RTL and testbench

Request-side controller for a single-port 1RW SRAM macro with pins A/CSB/WEB/OEB/I/O. It accepts read and write requests on a valid/ready stream and drives the macro's pins. It times the output-enable window, captures read data, and returns it in order on a valid/ready response stream with back-pressure. The macro's CE pin is tied to `clk` at the wrapper level; this block owns every other macro pin.

---
 rtl/sram1rw_ctrl_if.sv | 25 ++
 rtl/sram1rw_ctrl.sv | 125 ++++++++++++
 tb/tb_sram1rw_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram1rw_ctrl_if.sv
// Request/response stream bundle between a client and the sram1rw_ctrl block.
// Handshake: a beat transfers on a rising edge where valid and ready are both high; valid must not wait on ready.
interface sram1rw_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 46
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram1rw_ctrl.sv
// Request-side controller for a 1RW SRAM macro: issues requests, times OEB, returns read data in order.
// Define SRAM1RW_CTRL_INREG_EN to register the macro input pins (read latency 3 instead of 2).
module sram1rw_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 46,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  sram1rw_ctrl_if.slave               bus,
  output logic [ADDR_WIDTH-1:0]       sram_A,
  output logic                        sram_CSB,
  output logic                        sram_WEB,
  output logic                        sram_OEB,
  output logic [DATA_WIDTH-1:0]       sram_I,
  input  logic [DATA_WIDTH-1:0]       sram_O,
  output logic [$clog2(RSP_DEPTH):0]  cnt
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW:0] PTR_ONE = 1;

  logic accept;
  logic rd_accept;
  logic push;
  logic pop;
  logic capture;

  // Credit = reads in flight + FIFO occupancy, so the FIFO can never be overrun.
  assign bus.req_ready = ~reset & (cnt < CW'(RSP_DEPTH));
  assign accept        = bus.req_valid & bus.req_ready;
  assign rd_accept     = accept & ~bus.req_write;
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign push          = capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (rd_accept & ~pop) begin
      cnt <= cnt + CW'(1);
    end else if (~rd_accept & pop) begin
      cnt <= cnt - CW'(1);
    end
  end

`ifdef SRAM1RW_CTRL_INREG_EN
  logic rd_p1;
  logic rd_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_A   <= '0;
      sram_CSB <= 1'b1;
      sram_WEB <= 1'b1;
      sram_I   <= '0;
      rd_p1    <= 1'b0;
      rd_p2    <= 1'b0;
    end else begin
      sram_CSB <= ~accept;
      sram_WEB <= ~(accept & bus.req_write);
      sram_I   <= accept ? bus.req_wdata : '0;
      if (accept) sram_A <= bus.req_addr;
      rd_p1    <= rd_accept;
      rd_p2    <= rd_p1;
    end
  end

  assign capture = rd_p2;
`else
  logic [ADDR_WIDTH-1:0] a_hold;
  logic                  rd_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_hold <= '0;
      rd_p1  <= 1'b0;
    end else begin
      if (accept) a_hold <= bus.req_addr;
      rd_p1 <= rd_accept;
    end
  end

  // Idle cycles keep the last address on the pins to avoid needless toggling.
  always_comb begin
    sram_CSB = ~accept;
    sram_WEB = ~(accept & bus.req_write);
    sram_A   = accept ? bus.req_addr : a_hold;
    sram_I   = accept ? bus.req_wdata : '0;
  end

  assign capture = rd_p1;
`endif

  assign sram_OEB = ~capture;

  // Response FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic                  empty;
  logic                  full;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= sram_O;
  end

  assign bus.rsp_valid = ~empty;
  assign bus.rsp_rdata = empty ? '0 : mem[rd_ptr[PW-1:0]];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) push |-> !full)
    else $error("sram1rw_ctrl: push into full response fifo");
endmodule

// File: tb/tb_sram1rw_ctrl.sv
// Directed bench for sram1rw_ctrl with a behavioural 1RW macro and an in-order read scoreboard.
module tb_sram1rw_ctrl;
  localparam int AW    = 8;
  localparam int DW    = 46;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SRAM1RW_CTRL_INREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [DW-1:0] PATTERN = 46'h2A5A5A5A5A5;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram1rw_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [AW-1:0] sram_A;
  logic          sram_CSB;
  logic          sram_WEB;
  logic          sram_OEB;
  logic [DW-1:0] sram_I;
  wire  [DW-1:0] sram_O;
  logic [CW-1:0] cnt;

  sram1rw_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .sram_A   (sram_A),
    .sram_CSB (sram_CSB),
    .sram_WEB (sram_WEB),
    .sram_OEB (sram_OEB),
    .sram_I   (sram_I),
    .sram_O   (sram_O),
    .cnt      (cnt)
  );

  // behavioural macro: samples pins on the rising edge, drives O only while OEB is low
  logic [DW-1:0] macro_mem [256];
  logic [DW-1:0] macro_dout;
  always @(posedge clk) begin
    if (!sram_CSB) begin
      if (!sram_WEB) macro_mem[sram_A] <= sram_I;
      else           macro_dout <= macro_mem[sram_A];
    end
  end
  assign sram_O = sram_OEB ? 'z : macro_dout;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [256];
  int checks = 0;
  int errors = 0;
  int n_acc, n_rsp, cyc, first_rsp, last_rsp, acc5_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({pfx, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    chk({pfx, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({pfx, "_csb"},       64'(sram_CSB),      64'd1);
    chk({pfx, "_web"},       64'(sram_WEB),      64'd1);
    chk({pfx, "_oeb"},       64'(sram_OEB),      64'd1);
    chk({pfx, "_a"},         64'(sram_A),        64'd0);
    chk({pfx, "_i"},         64'(sram_I),        64'd0);
    chk({pfx, "_cnt"},       64'(cnt),           64'd0);
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (bus.req_valid && bus.req_ready) begin
      n_acc++;
      if (bus.req_write) model_mem[bus.req_addr] = bus.req_wdata;
      else               exp_q.push_back(model_mem[bus.req_addr]);
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("rsp_data", 64'(bus.rsp_rdata), 64'(exp_q.pop_front()));
      if (first_rsp < 0) first_rsp = cyc;
      last_rsp = cyc;
      n_rsp++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 1'b0, '0, '0);
    bus.rsp_ready = 1'b0;
    cyc = 0;
    first_rsp = -1;

    // reset values at power-up, then release
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset = 1'b0;
    #1;
    chk("por_ready_after_release", 64'(bus.req_ready), 64'd1);

    // mid-stream reset: two reads and a write in progress
    drive(1'b1, 1'b0, 8'h01, '0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 8'h02, '0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 8'h55, 46'h15555);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("mid");
    drive(1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_ready_after_release", 64'(bus.req_ready), 64'd1);
    exp_q.delete();

    // write then read back-to-back, OEB window and latency
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < LAT + 4; k++) begin
      if (k == 0)      drive(1'b1, 1'b1, 8'h10, PATTERN);
      else if (k == 1) drive(1'b1, 1'b0, 8'h10, '0);
      else             drive(1'b0, 1'b0, 8'h10, '0);
      @(negedge clk);
      if (k == LAT - 2) begin
        chk("wr_csb", 64'(sram_CSB), 64'd0);
        chk("wr_web", 64'(sram_WEB), 64'd0);
        chk("wr_a",   64'(sram_A),   64'h10);
        chk("wr_i",   64'(sram_I),   64'(PATTERN));
      end
      if (k == LAT - 1) begin
        chk("rd_csb", 64'(sram_CSB), 64'd0);
        chk("rd_web", 64'(sram_WEB), 64'd1);
        chk("rd_a",   64'(sram_A),   64'h10);
      end
      chk("oeb_window", 64'(sram_OEB), 64'(k != LAT));
      chk("rsp_valid_timing", 64'(bus.rsp_valid), 64'(k == LAT + 1));
      if (k == LAT + 1) chk("raw_data", 64'(bus.rsp_rdata), 64'(PATTERN));
      @(posedge clk); #1;
    end
    model_mem[8'h10] = PATTERN;

    // full throughput: 256 writes of data=addr, then 256 reads
    n_acc = 0;
    for (int t = 0; t < 600 && n_acc < 256; t++) begin
      drive(1'b1, 1'b1, AW'(n_acc), DW'(n_acc));
      cycle();
    end
    chk("tp_writes_accepted", 64'(n_acc), 64'd256);
    n_acc = 0;
    n_rsp = 0;
    first_rsp = -1;
    for (int t = 0; t < 600 && n_rsp < 256; t++) begin
      if (n_acc < 256) drive(1'b1, 1'b0, AW'(n_acc), '0);
      else             drive(1'b0, 1'b0, '0, '0);
      cycle();
    end
    chk("tp_rsp_count", 64'(n_rsp), 64'd256);
    chk("tp_no_bubbles", 64'(last_rsp - first_rsp), 64'd255);

    // back-pressure: six reads against a stalled consumer
    bus.rsp_ready = 1'b0;
    n_acc = 0;
    n_rsp = 0;
    first_rsp = -1;
    acc5_cyc = -1;
    for (int t = 0; t < 8; t++) begin
      drive(n_acc < 6, 1'b0, AW'(n_acc), '0);
      cycle();
    end
    chk("bp_accepted", 64'(n_acc), 64'(DEPTH));
    chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
    chk("bp_rsp_waiting", 64'(bus.rsp_valid), 64'd1);
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 40 && n_rsp < 6; t++) begin
      drive(n_acc < 6, 1'b0, AW'(n_acc), '0);
      cycle();
      if (n_acc == 5 && acc5_cyc < 0) acc5_cyc = cyc - 1;
    end
    chk("bp_rsp_count", 64'(n_rsp), 64'd6);
    chk("bp_5th_after_pop", 64'(acc5_cyc > first_rsp), 64'd1);

    // simultaneous push/pop with credit exhausted
    drive(1'b0, 1'b0, '0, '0);
    bus.rsp_ready = 1'b0;
    n_acc = 0;
    for (int t = 0; t < DEPTH + LAT + 2; t++) begin
      drive(n_acc < DEPTH, 1'b0, AW'(8'h20 + n_acc), '0);
      cycle();
    end
    chk("ss_cnt_full", 64'(cnt), 64'(DEPTH));
    chk("ss_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      drive(1'b1, 1'b0, AW'(8'h20 + n_acc), '0);
      cycle();
      chk("ss_cnt_steady", 64'(cnt), 64'(DEPTH - 1));
      chk("ss_valid_steady", 64'(bus.rsp_valid), 64'd1);
    end
    drive(1'b0, 1'b0, '0, '0);
    for (int t = 0; t < 20 && (exp_q.size() != 0 || bus.rsp_valid); t++) cycle();
    chk("ss_drained", 64'(exp_q.size()), 64'd0);
    chk("ss_cnt_zero", 64'(cnt), 64'd0);

    // reset while two reads are in flight
    drive(1'b1, 1'b0, 8'h30, '0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 8'h31, '0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0);
    chk("if_cnt_before", 64'(cnt), 64'd2);
    reset = 1'b1;
    #1;
    chk("if_cnt_in_reset", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("if_no_rsp", 64'(bus.rsp_valid), 64'd0);
      chk("if_oeb_idle", 64'(sram_OEB), 64'd1);
    end
    chk("if_cnt_after", 64'(cnt), 64'd0);

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
